uart_frame_parser: RTL

- Byte-stream consumer placed directly after the UART receiver. Takes each received byte (rx_data qualified by the one-cycle po_flag strobe) and parses it against the team's serial command frame format.
- Frame format: HEAD0, HEAD1, CMD, LEN, LEN payload bytes, CSUM.
- Emits the command code, a per-byte payload stream with an index, and a single pass/fail result per frame for the register/command layer.

---
 rtl/uart_frame_parser.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Parses the byte stream coming out of the UART receiver against the
//   serial command frame format:
//     HEAD0, HEAD1, CMD, LEN, LEN payload bytes, CSUM
//   CSUM is the 8-bit wrapping sum of CMD, LEN and every payload byte.
//   Payload bytes are forwarded as they arrive. A frame that later fails
//   is reported through frame_err, and the consumer drops its bytes.
//
//   Optional feature (define FRAME_TIMEOUT_EN):
//     An inter-byte idle counter aborts a frame that stalls mid-way
//     (err_code=3). Without the macro the parser waits indefinitely.
//
// Ports
//   sclk        in   system clock
//   s_rst_n     in   asynchronous active-low reset
//   rx_data     in   [7:0] received byte, valid while po_flag=1
//   po_flag     in   one-cycle byte-valid strobe
//   frame_cmd   out  [7:0] CMD byte of the current/last frame
//   pl_data     out  [7:0] payload byte
//   pl_idx      out  [7:0] payload byte index, 0-based
//   pl_vld      out  one-cycle payload strobe
//   frame_done  out  one-cycle pulse, frame accepted with good checksum
//   frame_err   out  one-cycle pulse, frame aborted
//   err_code    out  [1:0] abort reason (1=checksum, 2=bad LEN, 3=timeout),
//                    held until the next frame_err
module uart_frame_parser #(
  parameter logic [7:0]  HEAD0       = 8'h55,
  parameter logic [7:0]  HEAD1       = 8'hAA,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 104160
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] rx_data,
  input  logic       po_flag,
  output logic [7:0] frame_cmd,
  output logic [7:0] pl_data,
  output logic [7:0] pl_idx,
  output logic       pl_vld,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_H1,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  // LEN is an 8-bit field and the idle counter is 17 bits wide; reject
  // configurations that cannot be represented.
  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
    $error("uart_frame_parser: MAX_LEN must be in 1..255");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 131072) begin : g_bad_timeout
    $error("uart_frame_parser: TIMEOUT_CYC must be in 2..131072");
  end

  state_t     state;
  logic [7:0] sum;
  logic [7:0] len;
  logic [7:0] idx;

`ifdef FRAME_TIMEOUT_EN
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);
  logic [16:0] tmo_cnt;
`endif

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= S_IDLE;
      sum        <= '0;
      len        <= '0;
      idx        <= '0;
      frame_cmd  <= '0;
      pl_data    <= '0;
      pl_idx     <= '0;
      pl_vld     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
`ifdef FRAME_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      pl_vld     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

`ifdef FRAME_TIMEOUT_EN
      // Idle time since the last accepted byte; held at zero while idle.
      if (state == S_IDLE || po_flag) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 17'd1;
      end
`endif

      if (po_flag) begin
        unique case (state)
          S_IDLE: begin
            if (rx_data == HEAD0) begin
              state <= S_H1;
            end
          end

          S_H1: begin
            // A repeated HEAD0 may be the real start of a frame.
            if (rx_data == HEAD1) begin
              state <= S_CMD;
            end else if (rx_data != HEAD0) begin
              state <= S_IDLE;
            end
          end

          S_CMD: begin
            frame_cmd <= rx_data;
            sum       <= rx_data;
            state     <= S_LEN;
          end

          S_LEN: begin
            sum <= sum + rx_data;
            if (rx_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= S_IDLE;
            end else if (rx_data == 8'd0) begin
              state <= S_CSUM;
            end else begin
              len   <= rx_data;
              idx   <= '0;
              state <= S_DATA;
            end
          end

          S_DATA: begin
            pl_data <= rx_data;
            pl_idx  <= idx;
            pl_vld  <= 1'b1;
            sum     <= sum + rx_data;
            idx     <= idx + 8'd1;
            if (idx == len - 8'd1) begin
              state <= S_CSUM;
            end
          end

          S_CSUM: begin
            if (rx_data == sum) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
            end
            state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
`ifdef FRAME_TIMEOUT_EN
      // An arriving byte always takes priority over expiry.
      else if (state != S_IDLE && tmo_cnt == TMO_LAST) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= S_IDLE;
        tmo_cnt   <= '0;
      end
`endif
    end
  end

endmodule
